// File: rtl/fetch_sequencer.sv
// Control sequencer for the 24-bit ROM / 8-bit PC fetch stage: decode, flags, call stack, MUL hold, HALT/fault.
// PCSrc/target/reg_we are combinational from state and instr (zero-delay-slot branches); holds are branch-to-self.
module fetch_sequencer #(
  parameter int STACK_DEPTH = 4,
  parameter int MUL_LAT     = 3
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [23:0]                   instr,
  input  logic [7:0]                    pc,
  input  logic [2:0]                    alu_flags,
  output logic                          PCSrc,
  output logic [7:0]                    target,
  output logic                          reg_we,
  output logic [2:0]                    flags,
  output logic                          halted,
  output logic                          fault,
  output logic [$clog2(STACK_DEPTH):0]  sp
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [3:0] CNT_INIT = 4'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_JMP  = 4'd3;
  localparam logic [3:0] OP_BCC  = 4'd4;
  localparam logic [3:0] OP_CALL = 4'd5;
  localparam logic [3:0] OP_RET  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       flags_q, flags_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             push_en;
  logic [7:0]       stack_q [STACK_DEPTH];

  logic [3:0]       op;
  logic [3:0]       cond;
  logic [7:0]       imm;
  logic [7:0]       pc_inc;
  logic [SPW-1:0]   sp_m1;
  logic [IW-1:0]    top_idx;
  logic [7:0]       stack_top;
  logic             stack_full;
  logic             stack_empty;
  logic             cond_true;
  logic             unused_bits;

  assign op          = instr[23:20];
  assign cond        = instr[19:16];
  assign imm         = instr[7:0];
  assign pc_inc      = pc + 8'd1;
  assign sp_m1       = sp_q - SPW'(1);
  assign top_idx     = sp_m1[IW-1:0];
  assign stack_top   = stack_q[top_idx];
  assign stack_full  = (sp_q >= SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign unused_bits = ^{instr[15:8], sp_m1[IW]};

  // flags are {C,N,Z}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = flags_q[0];
      4'd2:    cond_true = ~flags_q[0];
      4'd3:    cond_true = flags_q[1];
      4'd4:    cond_true = ~flags_q[1];
      4'd5:    cond_true = flags_q[2];
      4'd6:    cond_true = ~flags_q[2];
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_RUN;
      flags_q <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Entries above sp are don't-care, so the array itself needs no reset.
  always_ff @(posedge CLK) begin
    if (push_en && !reset) begin
      stack_q[sp_q[IW-1:0]] <= pc_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    push_en = 1'b0;
    case (state_q)
      ST_RUN: begin
        case (op)
          OP_NOP, OP_JMP, OP_BCC: ;
          OP_ALU:  flags_d = alu_flags;
          OP_MUL: begin
            if (MUL_LAT > 1) begin
              cnt_d   = CNT_INIT;
              state_d = ST_MUL_WAIT;
            end
          end
          OP_CALL: begin
            if (!stack_full) begin
              push_en = 1'b1;
              sp_d    = sp_q + SPW'(1);
            end else begin
              fault_d = 1'b1;
              state_d = ST_HALT;
            end
          end
          OP_RET: begin
            if (!stack_empty) begin
              sp_d = sp_m1;
            end else begin
              fault_d = 1'b1;
              state_d = ST_HALT;
            end
          end
          OP_HALT: state_d = ST_HALT;
          default: begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_MUL_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
  end

  // Any hold (MUL, HALT, fault) is a branch to the current PC.
  always_comb begin
    PCSrc  = 1'b0;
    target = imm;
    reg_we = 1'b0;
    if (reset) begin
      target = 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          case (op)
            OP_NOP:  ;
            OP_ALU:  reg_we = 1'b1;
            OP_MUL: begin
              if (MUL_LAT == 1) begin
                reg_we = 1'b1;
              end else begin
                PCSrc  = 1'b1;
                target = pc;
              end
            end
            OP_JMP:  PCSrc = 1'b1;
            OP_BCC:  PCSrc = cond_true;
            OP_CALL: begin
              PCSrc = 1'b1;
              if (stack_full) target = pc;
            end
            OP_RET: begin
              PCSrc  = 1'b1;
              target = stack_empty ? pc : stack_top;
            end
            default: begin
              PCSrc  = 1'b1;
              target = pc;
            end
          endcase
        end
        ST_MUL_WAIT: begin
          if (cnt_q != 4'd0) begin
            PCSrc  = 1'b1;
            target = pc;
          end else begin
            reg_we = 1'b1;
          end
        end
        default: begin
          PCSrc  = 1'b1;
          target = pc;
        end
      endcase
    end
  end

  assign flags  = flags_q;
  assign sp     = sp_q;
  assign fault  = fault_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a behavioural PC register and ROM close the fetch loop around the DUT.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pc;
  logic [23:0] instr;
  logic [2:0]  alu_flags = 3'b000;
  logic        PCSrc, reg_we, halted, fault;
  logic [7:0]  target;
  logic [2:0]  flags;
  logic [2:0]  sp;

  // second instance with MUL_LAT=1, driven open-loop
  logic [23:0] instr1;
  logic [7:0]  pc1 = 8'h05;
  logic [2:0]  alu_flags1 = 3'b111;
  logic        PCSrc1, reg_we1, halted1, fault1;
  logic [7:0]  target1;
  logic [2:0]  flags1;
  logic [2:0]  sp1;

  logic [23:0] rom [256];
  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  assign instr = rom[pc];

  always @(posedge CLK) begin
    if (reset)      pc <= 8'h00;
    else if (PCSrc) pc <= target;
    else            pc <= pc + 8'h01;
  end

  fetch_sequencer #(.STACK_DEPTH(4), .MUL_LAT(3)) u_dut (
    .CLK(CLK), .reset(reset), .instr(instr), .pc(pc), .alu_flags(alu_flags),
    .PCSrc(PCSrc), .target(target), .reg_we(reg_we), .flags(flags),
    .halted(halted), .fault(fault), .sp(sp)
  );

  fetch_sequencer #(.STACK_DEPTH(4), .MUL_LAT(1)) u_dut_mul1 (
    .CLK(CLK), .reset(reset), .instr(instr1), .pc(pc1), .alu_flags(alu_flags1),
    .PCSrc(PCSrc1), .target(target1), .reg_we(reg_we1), .flags(flags1),
    .halted(halted1), .fault(fault1), .sp(sp1)
  );

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] cnd, input logic [7:0] imm);
    return {op, cnd, 8'h00, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Leaves reset high across one edge and clears the ROM; caller then loads a program.
  task automatic hold_reset();
    reset = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    instr1 = enc(4'h2, 4'h0, 8'h00);

    // Reset gating of the combinational outputs
    hold_reset();
    rom[0] = enc(4'h3, 4'h0, 8'h55);
    #1;
    chk("rst_pcsrc", PCSrc, 1'b0);
    chk("rst_target", target, 8'h00);
    chk("rst_regwe", reg_we, 1'b0);

    // NOP, NOP, JMP 0x10
    hold_reset();
    rom[2] = enc(4'h3, 4'h0, 8'h10);
    release_reset();
    chk("rs_pc", pc, 8'h00);
    chk("rs_flags", flags, 3'b000);
    chk("rs_sp", sp, 3'd0);
    chk("rs_halted", halted, 1'b0);
    chk("rs_fault", fault, 1'b0);
    chk("nop0_pcsrc", PCSrc, 1'b0);
    chk("mul1_pcsrc", PCSrc1, 1'b0);
    chk("mul1_regwe", reg_we1, 1'b1);
    step();
    chk("nop1_pc", pc, 8'h01);
    chk("nop1_pcsrc", PCSrc, 1'b0);
    chk("mul1_pcsrc_b", PCSrc1, 1'b0);
    chk("mul1_regwe_b", reg_we1, 1'b1);
    chk("mul1_flags", flags1, 3'b000);
    step();
    chk("jmp_pc", pc, 8'h02);
    chk("jmp_pcsrc", PCSrc, 1'b1);
    chk("jmp_target", target, 8'h10);
    step();
    chk("jmp_dest", pc, 8'h10);

    // ALU sets Z, BCC Z taken
    hold_reset();
    rom[0] = enc(4'h1, 4'h0, 8'h00);
    rom[1] = enc(4'h4, 4'h1, 8'h40);
    alu_flags = 3'b001;
    release_reset();
    chk("alu_regwe", reg_we, 1'b1);
    step();
    chk("alu_flags", flags, 3'b001);
    chk("bccz_pcsrc", PCSrc, 1'b1);
    chk("bccz_target", target, 8'h40);
    step();
    chk("bccz_pc", pc, 8'h40);

    // BCC !Z not taken
    hold_reset();
    rom[0] = enc(4'h1, 4'h0, 8'h00);
    rom[1] = enc(4'h4, 4'h2, 8'h40);
    release_reset();
    step();
    chk("bccnz_flags", flags, 3'b001);
    chk("bccnz_pcsrc", PCSrc, 1'b0);
    step();
    chk("bccnz_pc", pc, 8'h02);
    alu_flags = 3'b000;

    // MUL at pc 5, three-cycle hold
    hold_reset();
    rom[5] = enc(4'h2, 4'h0, 8'h00);
    release_reset();
    repeat (5) step();
    chk("mul_c1_pc", pc, 8'h05);
    chk("mul_c1_regwe", reg_we, 1'b0);
    chk("mul_c1_pcsrc", PCSrc, 1'b1);
    chk("mul_c1_target", target, 8'h05);
    step();
    chk("mul_c2_pc", pc, 8'h05);
    chk("mul_c2_regwe", reg_we, 1'b0);
    step();
    chk("mul_c3_pc", pc, 8'h05);
    chk("mul_c3_regwe", reg_we, 1'b1);
    chk("mul_c3_pcsrc", PCSrc, 1'b0);
    step();
    chk("mul_after_pc", pc, 8'h06);
    chk("mul_after_regwe", reg_we, 1'b0);

    // CALL at 0xFF wraps return address to 0x00
    hold_reset();
    rom[8'h00] = enc(4'h3, 4'h0, 8'hFF);
    rom[8'hFF] = enc(4'h5, 4'h0, 8'h20);
    rom[8'h20] = enc(4'h6, 4'h0, 8'h00);
    release_reset();
    step();
    chk("call_pc", pc, 8'hFF);
    chk("call_sp0", sp, 3'd0);
    chk("call_target", target, 8'h20);
    step();
    chk("ret_pc", pc, 8'h20);
    chk("ret_sp1", sp, 3'd1);
    chk("ret_pcsrc", PCSrc, 1'b1);
    chk("ret_target", target, 8'h00);
    step();
    chk("ret_dest", pc, 8'h00);
    chk("ret_sp0", sp, 3'd0);

    // LIFO order: two calls, two returns
    hold_reset();
    rom[8'h00] = enc(4'h5, 4'h0, 8'h10);
    rom[8'h10] = enc(4'h5, 4'h0, 8'h20);
    rom[8'h20] = enc(4'h6, 4'h0, 8'h00);
    rom[8'h11] = enc(4'h6, 4'h0, 8'h00);
    release_reset();
    step();
    step();
    chk("lifo_sp2", sp, 3'd2);
    step();
    chk("lifo_ret1", pc, 8'h11);
    step();
    chk("lifo_ret2", pc, 8'h01);
    chk("lifo_sp0", sp, 3'd0);

    // Five nested calls overflow a depth-4 stack
    hold_reset();
    rom[8'h00] = enc(4'h5, 4'h0, 8'h10);
    rom[8'h10] = enc(4'h5, 4'h0, 8'h20);
    rom[8'h20] = enc(4'h5, 4'h0, 8'h30);
    rom[8'h30] = enc(4'h5, 4'h0, 8'h40);
    rom[8'h40] = enc(4'h5, 4'h0, 8'h50);
    release_reset();
    repeat (4) step();
    chk("ovf_pc", pc, 8'h40);
    chk("ovf_sp", sp, 3'd4);
    chk("ovf_pcsrc", PCSrc, 1'b1);
    chk("ovf_target", target, 8'h40);
    step();
    chk("ovf_fault", fault, 1'b1);
    chk("ovf_halted", halted, 1'b1);
    chk("ovf_sp_kept", sp, 3'd4);
    repeat (3) step();
    chk("ovf_pc_frozen", pc, 8'h40);
    pulse_reset();
    chk("ovf_rst_fault", fault, 1'b0);
    chk("ovf_rst_sp", sp, 3'd0);

    // RET on empty stack
    hold_reset();
    rom[0] = enc(4'h6, 4'h0, 8'h33);
    release_reset();
    chk("unf_pcsrc", PCSrc, 1'b1);
    chk("unf_target", target, 8'h00);
    step();
    chk("unf_fault", fault, 1'b1);
    chk("unf_halted", halted, 1'b1);
    chk("unf_sp", sp, 3'd0);
    chk("unf_pc", pc, 8'h00);

    // Illegal opcode
    hold_reset();
    rom[0] = enc(4'h9, 4'h0, 8'h77);
    release_reset();
    chk("ill_pcsrc", PCSrc, 1'b1);
    chk("ill_target", target, 8'h00);
    chk("ill_regwe", reg_we, 1'b0);
    step();
    chk("ill_fault", fault, 1'b1);

    // ALU, CALL 9, HALT at 9; then reset while halted
    hold_reset();
    rom[0] = enc(4'h1, 4'h0, 8'h00);
    rom[1] = enc(4'h5, 4'h0, 8'h09);
    rom[9] = enc(4'h7, 4'h0, 8'h00);
    alu_flags = 3'b110;
    release_reset();
    step();
    step();
    chk("halt_pc", pc, 8'h09);
    chk("halt_pcsrc", PCSrc, 1'b1);
    chk("halt_target", target, 8'h09);
    alu_flags = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_hold_pc", pc, 8'h09);
      chk("halt_hold_regwe", reg_we, 1'b0);
    end
    chk("halt_halted", halted, 1'b1);
    chk("halt_flags", flags, 3'b110);
    chk("halt_sp", sp, 3'd1);
    chk("halt_fault", fault, 1'b0);
    pulse_reset();
    chk("hrst_pc", pc, 8'h00);
    chk("hrst_halted", halted, 1'b0);
    chk("hrst_flags", flags, 3'b000);
    chk("hrst_sp", sp, 3'd0);
    chk("hrst_regwe", reg_we, 1'b1);

    // Reset in the middle of a MUL
    hold_reset();
    rom[0] = enc(4'h1, 4'h0, 8'h00);
    rom[1] = enc(4'h2, 4'h0, 8'h00);
    alu_flags = 3'b111;
    release_reset();
    step();
    chk("mrst_flags_set", flags, 3'b111);
    step();
    chk("mrst_wait_pc", pc, 8'h01);
    chk("mrst_wait_pcsrc", PCSrc, 1'b1);
    alu_flags = 3'b000;
    pulse_reset();
    chk("mrst_pc", pc, 8'h00);
    chk("mrst_flags", flags, 3'b000);
    chk("mrst_sp", sp, 3'd0);
    chk("mrst_fault", fault, 1'b0);
    chk("mrst_pcsrc", PCSrc, 1'b0);
    chk("mrst_regwe", reg_we, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control sequencer for the 24-bit instruction ROM and 8-bit PC fetch stage.
- Decodes the instruction currently presented by the ROM and drives the PC-select and branch-target inputs of the fetch stage.
- Owns the flag register, condition evaluation, a call/return address stack, multi-cycle MUL holds and the HALT/fault state.
- The fetch stage has no enable; every hold is a branch to the current PC.

Parameters:
STACK_DEPTH, 4, number of return-address entries (power of two, 2..16)
MUL_LAT, 3, cycles a MUL occupies the fetch stage (1..15; 1 means no hold)

Ports:
CLK  input  1  clock
reset  input  1  synchronous active-high reset, shared with the fetch stage
instr  input  24  current instruction from the ROM (combinational from the PC)
pc  input  8  current PC value
alu_flags  input  3  {C,N,Z} from the ALU for the current instruction
PCSrc  output  1  1 = load target into the PC next edge, 0 = PC+1
target  output  8  branch target, wired to the fetch-stage immediate input
reg_we  output  1  register-file write enable
flags  output  3  registered {C,N,Z}
halted  output  1  sequencer is in HALT
fault  output  1  sticky: stack overflow/underflow or illegal opcode
sp  output  log2(STACK_DEPTH)+1  stack occupancy

Behaviour:
- Interface: reset is synchronous, active-high; clock CLK. All state updates on posedge CLK.
- Field decode:
  - op = instr[23:20]
  - cond = instr[19:16]
  - imm = instr[7:0]
- States: RUN, MUL_WAIT, HALT.
- Reset:
  - state RUN; flags 0; sp 0; mul counter 0; halted 0; fault 0.
  - While reset is high, PCSrc=0, reg_we=0 and target=0 regardless of instr.
  - Reset mid-MUL or in HALT returns to RUN with all state cleared.
- PCSrc, target and reg_we are combinational from state, instr, pc and flags, giving zero-delay-slot branches.
- RUN decode (outputs in the same cycle; default PCSrc=0, target=imm, reg_we=0):
  - 0 NOP: nothing.
  - 1 ALU: reg_we=1; flags <= alu_flags at the edge.
  - 2 MUL:
    - MUL_LAT=1: behaves like ALU without a flag update.
    - Otherwise PCSrc=1, target=pc, counter <= MUL_LAT-2, go to MUL_WAIT.
  - 3 JMP: PCSrc=1, target=imm.
  - 4 BCC: PCSrc=cond_true, target=imm. Conditions:
    - 0 always; 1 Z; 2 !Z; 3 N; 4 !N; 5 C; 6 !C; 7..15 never.
    - Uses the registered flags, so an ALU op immediately before a BCC is visible to it.
  - 5 CALL:
    - If sp<STACK_DEPTH: push pc+1 (8-bit wrap, 255 -> 0), sp++, PCSrc=1, target=imm.
    - Else: fault, enter HALT.
  - 6 RET:
    - If sp>0: PCSrc=1, target=top entry, sp--.
    - Else: fault, enter HALT.
  - 7 HALT: PCSrc=1, target=pc, enter HALT.
  - 8..15: illegal; fault, enter HALT.
  - On every fault entry: PCSrc=1, target=pc, reg_we=0 that cycle.
- MUL_WAIT:
  - While counter != 0: PCSrc=1, target=pc, counter--.
  - When counter == 0: reg_we=1, PCSrc=0, return to RUN.
  - Total MUL occupancy is MUL_LAT cycles, with exactly one reg_we pulse on the last cycle.
- HALT:
  - PCSrc=1, target=pc, so the PC is frozen; reg_we=0; halted=1.
  - Flags and stack are frozen.
  - Exits only on reset. fault stays set until reset.
- The stack is LIFO and indexed by sp. Entries beyond sp are don't-care.
- A CALL never both pushes and faults. A failed push or pop leaves sp unchanged.
- Flag register updates only on op 1 in RUN.

Test Plan:
- Reset then program NOP,NOP,JMP 0x10 at 0..2 -> PC sequence 0,1,2,0x10. PCSrc=1 only in the cycle pc=2, with target=0x10.
- ALU with alu_flags=3'b001, then BCC cond=1 imm=0x40 -> flags=001 after the ALU edge; branch taken, PC=0x40. Repeat with cond=2 -> not taken, PC increments.
- MUL at pc=5 with MUL_LAT=3 -> pc stays 5 for 3 cycles, reg_we high only in the third cycle, then pc=6. MUL_LAT=1 -> no hold, reg_we in the single cycle.
- CALL 0x20 at pc=0xFF, RET at 0x20 -> return address 0x00, PC returns to 0x00, sp goes 0->1->0.
- Five nested CALLs with STACK_DEPTH=4 -> the fifth faults: fault=1, halted=1, pc frozen at the fifth CALL, sp=4. RET on an empty stack -> fault, sp=0.
- HALT at pc=9 -> pc stays 9 for 10+ cycles with reg_we=0. Assert reset while halted, and separately mid-MUL -> the next cycle has state RUN, pc=0, flags=0, sp=0, fault=0.
